// File: rtl/sprite_compositor_if.sv
// ============================================================================
//  Module   : sprite_compositor_if
//  Purpose  : Scan position, layer geometry/colour and composite result bundle
//             between the sprite generators and sprite_compositor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sprite_compositor_if #(
    parameter int LAYERS  = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 12
);
    logic [1:0]                game_state;
    logic [X_W-1:0]            x;
    logic [Y_W-1:0]            y;
    logic                      frame_start;
    logic [LAYERS-1:0]         layer_en;
    logic [LAYERS*X_W-1:0]     layer_x;
    logic [LAYERS*X_W-1:0]     layer_w;
    logic [LAYERS*Y_W-1:0]     layer_y;
    logic [LAYERS*Y_W-1:0]     layer_h;
    logic [LAYERS*COLOR_W-1:0] layer_color;
    logic [COLOR_W-1:0]        bg_color;

    logic [COLOR_W-1:0]        pix_color;
    logic                      hit_any;
    logic [$clog2(LAYERS)-1:0] hit_idx;
    logic [LAYERS-1:0]         collision;
    logic                      collision_valid;

    modport master (
        output game_state, x, y, frame_start, layer_en, layer_x, layer_w,
               layer_y, layer_h, layer_color, bg_color,
        input  pix_color, hit_any, hit_idx, collision, collision_valid
    );

    modport slave (
        input  game_state, x, y, frame_start, layer_en, layer_x, layer_w,
               layer_y, layer_h, layer_color, bg_color,
        output pix_color, hit_any, hit_idx, collision, collision_valid
    );
endinterface

`default_nettype wire

// File: rtl/sprite_compositor.sv
// ============================================================================
//  Module   : sprite_compositor
//  Purpose  : Two-stage priority compositor of LAYERS sprite rectangles over a
//             background, with game-state override colours. Per-frame
//             player-vs-layer collision flags are built only when
//             COMPOSITOR_COLLISION_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_compositor #(
    parameter int                 LAYERS     = 4,
    parameter int                 X_W        = 10,
    parameter int                 Y_W        = 9,
    parameter int                 COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] TRANSP_KEY = 12'hF0F
) (
    input wire              clk,
    input wire              rst,
    sprite_compositor_if.slave bus
);

    localparam int         c_idx_w   = $clog2(LAYERS);
    localparam logic [1:0] c_GS_INIT = 2'b00;
    localparam logic [1:0] c_GS_RUN  = 2'b01;
    localparam logic [1:0] c_GS_OVER = 2'b10;

    // ------------------------------------------------------------------
    // Stage 1: box test and transparency per layer
    // ------------------------------------------------------------------
    logic [LAYERS-1:0] w_opaque;

    genvar gi;
    generate
        for (gi = 0; gi < LAYERS; gi++) begin : g_layer
            logic [X_W-1:0] w_rel_x;
            logic [Y_W-1:0] w_rel_y;

            // Unsigned modular difference gives inclusive-left, exclusive-right
            // bounds and handles boxes that wrap past the coordinate limit.
            assign w_rel_x = bus.x - bus.layer_x[gi*X_W +: X_W];
            assign w_rel_y = bus.y - bus.layer_y[gi*Y_W +: Y_W];
            assign w_opaque[gi] = bus.layer_en[gi]
                                & (w_rel_x < bus.layer_w[gi*X_W +: X_W])
                                & (w_rel_y < bus.layer_h[gi*Y_W +: Y_W])
                                & (bus.layer_color[gi*COLOR_W +: COLOR_W] != TRANSP_KEY);
        end
    endgenerate

    logic [LAYERS-1:0]         r_s1_opaque;
    logic [LAYERS*COLOR_W-1:0] r_s1_color;
    logic [COLOR_W-1:0]        r_s1_bg;
    logic [1:0]                r_s1_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_opaque <= '0;
            r_s1_color  <= '0;
            r_s1_bg     <= '0;
            r_s1_state  <= '0;
        end else begin
            r_s1_opaque <= w_opaque;
            r_s1_color  <= bus.layer_color;
            r_s1_bg     <= bus.bg_color;
            r_s1_state  <= bus.game_state;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority select and game-state override
    // ------------------------------------------------------------------
    logic               w_hit;
    logic [c_idx_w-1:0] w_idx;
    logic [COLOR_W-1:0] w_layer_col;
    logic [COLOR_W-1:0] w_bg_key;
    logic [COLOR_W-1:0] w_pix;

    always_comb begin
        w_hit       = 1'b0;
        w_idx       = '0;
        w_layer_col = '0;
        // Walk from the lowest priority upward so layer 0 overrides last.
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (r_s1_opaque[i]) begin
                w_hit       = 1'b1;
                w_idx       = c_idx_w'(i);
                w_layer_col = r_s1_color[i*COLOR_W +: COLOR_W];
            end
        end

        w_bg_key = (r_s1_bg == TRANSP_KEY) ? '0 : r_s1_bg;

        case (r_s1_state)
            c_GS_INIT: w_pix = COLOR_W'(12'hF00);
            c_GS_RUN:  w_pix = w_hit ? w_layer_col : w_bg_key;
            c_GS_OVER: w_pix = w_bg_key;
            default:   w_pix = COLOR_W'(12'h00F);
        endcase
    end

    logic [COLOR_W-1:0] r_pix;
    logic               r_hit_any;
    logic [c_idx_w-1:0] r_hit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix     <= '0;
            r_hit_any <= 1'b0;
            r_hit_idx <= '0;
        end else begin
            r_pix     <= w_pix;
            r_hit_any <= w_hit;
            r_hit_idx <= w_idx;
        end
    end

    assign bus.pix_color = r_pix;
    assign bus.hit_any   = r_hit_any;
    assign bus.hit_idx   = r_hit_idx;

    // ------------------------------------------------------------------
    // Player-vs-layer collision accumulation
    // ------------------------------------------------------------------
`ifdef COMPOSITOR_COLLISION_EN
    logic [LAYERS-1:0] w_pair;
    logic [LAYERS-1:0] r_acc;
    logic [LAYERS-1:0] r_collision;
    logic              r_collision_valid;

    assign w_pair = (r_s1_opaque[0] && (r_s1_state == c_GS_RUN))
                  ? {r_s1_opaque[LAYERS-1:1], 1'b0} : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc             <= '0;
            r_collision       <= '0;
            r_collision_valid <= 1'b0;
        end else if (bus.frame_start) begin
            // A pair seen on the frame boundary belongs to the new frame.
            r_collision       <= r_acc;
            r_acc             <= w_pair;
            r_collision_valid <= 1'b1;
        end else begin
            r_acc             <= r_acc | w_pair;
            r_collision_valid <= 1'b0;
        end
    end

    assign bus.collision       = r_collision;
    assign bus.collision_valid = r_collision_valid;
`else
    logic w_unused_frame_start;

    assign w_unused_frame_start = bus.frame_start;
    assign bus.collision        = '0;
    assign bus.collision_valid  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// ============================================================================
//  Module   : tb_sprite_compositor
//  Purpose  : Directed self-checking bench for sprite_compositor (LAYERS=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sprite_compositor;

    localparam int LAYERS  = 4;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 12;

`ifdef COMPOSITOR_COLLISION_EN
    localparam bit c_COLL_EN = 1'b1;
`else
    localparam bit c_COLL_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    sprite_compositor_if #(
        .LAYERS(LAYERS), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)
    ) bus ();

    sprite_compositor #(
        .LAYERS(LAYERS), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
        .TRANSP_KEY(12'hF0F)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_layer(input int i, input int lx, input int ly,
                             input int lw, input int lh, input logic [11:0] col);
        bus.layer_x[i*X_W +: X_W]         = X_W'(lx);
        bus.layer_y[i*Y_W +: Y_W]         = Y_W'(ly);
        bus.layer_w[i*X_W +: X_W]         = X_W'(lw);
        bus.layer_h[i*Y_W +: Y_W]         = Y_W'(lh);
        bus.layer_color[i*COLOR_W +: COLOR_W] = col;
    endtask

    task automatic set_pix(input int px, input int py);
        bus.x = X_W'(px);
        bus.y = Y_W'(py);
    endtask

    // Apply a pixel, let it travel through both stages, then check.
    task automatic pix_check(input string tag, input int px, input int py,
                             input logic [11:0] e_col, input logic e_any, input int e_idx);
        set_pix(px, py);
        step(2);
        check_val({tag, "_col"}, 32'(bus.pix_color), 32'(e_col));
        check_val({tag, "_any"}, 32'(bus.hit_any),   32'(e_any));
        check_val({tag, "_idx"}, 32'(bus.hit_idx),   32'(e_idx));
    endtask

    task automatic pulse_frame;
        bus.frame_start = 1'b1;
        step(1);
        bus.frame_start = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        bus.game_state  = 2'b01;
        bus.x           = '0;
        bus.y           = '0;
        bus.frame_start = 1'b0;
        bus.layer_en    = '0;
        bus.layer_x     = '0;
        bus.layer_w     = '0;
        bus.layer_y     = '0;
        bus.layer_h     = '0;
        bus.layer_color = '0;
        bus.bg_color    = 12'h123;

        #3 rst = 1'b1;
        step(2);
        check_val("rst_pix",   32'(bus.pix_color),       32'h0);
        check_val("rst_any",   32'(bus.hit_any),         32'h0);
        check_val("rst_idx",   32'(bus.hit_idx),         32'h0);
        check_val("rst_coll",  32'(bus.collision),       32'h0);
        check_val("rst_cval",  32'(bus.collision_valid), 32'h0);
        rst = 1'b0;

        pix_check("bg0", 0, 0, 12'h123, 1'b0, 0);

        // Single layer 2 box at (100,50), 34x36; latency is exactly two clocks.
        set_layer(2, 100, 50, 34, 36, 12'h0F0);
        bus.layer_en = 4'b0100;
        set_pix(100, 50);
        step(1);
        check_val("lat1_col", 32'(bus.pix_color), 32'h123);
        step(1);
        check_val("lat2_col", 32'(bus.pix_color), 32'h0F0);
        check_val("lat2_idx", 32'(bus.hit_idx),   32'h2);
        pix_check("br_in",   133, 85, 12'h0F0, 1'b1, 2);
        pix_check("r_out",   134, 50, 12'h123, 1'b0, 0);
        pix_check("b_out",   100, 86, 12'h123, 1'b0, 0);
        pix_check("l_out",    99, 50, 12'h123, 1'b0, 0);

        // Layer 1 wraps past the right edge: covers x 1020..1023 and 0..5.
        set_layer(1, 1020, 0, 10, 20, 12'hABC);
        bus.layer_en = 4'b0110;
        pix_check("wrap_lo",   3, 5, 12'hABC, 1'b1, 1);
        pix_check("wrap_out",  6, 5, 12'h123, 1'b0, 0);
        pix_check("wrap_hi", 1020, 5, 12'hABC, 1'b1, 1);

        set_layer(3, 600, 300, 0, 10, 12'h333);
        bus.layer_en = 4'b1110;
        pix_check("zero_w", 600, 300, 12'h123, 1'b0, 0);

        // Overlapping layers 0 and 1.
        set_layer(0, 200, 100, 10, 10, 12'h111);
        set_layer(1, 205, 100, 10, 10, 12'h222);
        bus.layer_en = 4'b0011;
        pix_check("prio0", 206, 102, 12'h111, 1'b1, 0);
        set_layer(0, 200, 100, 10, 10, 12'hF0F);
        pix_check("transp0", 206, 102, 12'h222, 1'b1, 1);
        set_layer(0, 200, 100, 10, 10, 12'h111);

        bus.bg_color = 12'hF0F;
        pix_check("bg_key", 500, 300, 12'h000, 1'b0, 0);
        bus.bg_color = 12'h123;

        bus.game_state = 2'b00;
        pix_check("gs_init", 206, 102, 12'hF00, 1'b1, 0);
        bus.game_state = 2'b11;
        pix_check("gs_succ", 206, 102, 12'h00F, 1'b1, 0);
        bus.game_state = 2'b10;
        pix_check("gs_over", 206, 102, 12'h123, 1'b1, 0);
        bus.game_state = 2'b01;

        bus.layer_en = 4'b0010;
        pix_check("en_off0", 206, 102, 12'h222, 1'b1, 1);

        // Collision: layers 0 and 3 overlap at x 305..309.
        set_layer(0, 300, 200, 10, 10, 12'h111);
        set_layer(3, 305, 200, 10, 10, 12'h333);
        bus.layer_en = 4'b1001;
        set_pix(900, 400);
        step(3);
        pulse_frame();
        step(1);

        set_pix(306, 201);
        step(1);
        set_pix(900, 400);
        step(3);
        pulse_frame();
        check_val("coll_f1",   32'(bus.collision),       c_COLL_EN ? 32'h8 : 32'h0);
        check_val("cval_f1",   32'(bus.collision_valid), 32'(c_COLL_EN));
        step(1);
        check_val("cval_drop", 32'(bus.collision_valid), 32'h0);
        check_val("coll_hold", 32'(bus.collision),       c_COLL_EN ? 32'h8 : 32'h0);

        step(2);
        pulse_frame();
        check_val("coll_f2",   32'(bus.collision),       32'h0);
        check_val("cval_f2",   32'(bus.collision_valid), 32'(c_COLL_EN));

        bus.game_state = 2'b10;
        set_pix(306, 201);
        step(1);
        set_pix(900, 400);
        step(3);
        pulse_frame();
        check_val("coll_over", 32'(bus.collision), 32'h0);
        bus.game_state = 2'b01;

        // Overlap reaching stage 1 on the frame_start cycle lands in the new frame.
        step(2);
        set_pix(306, 201);
        step(1);
        bus.frame_start = 1'b1;
        set_pix(900, 400);
        step(1);
        bus.frame_start = 1'b0;
        check_val("coll_edge_old", 32'(bus.collision), 32'h0);
        step(3);
        pulse_frame();
        check_val("coll_edge_new", 32'(bus.collision), c_COLL_EN ? 32'h8 : 32'h0);

        // Asynchronous reset mid-frame with a pending overlap.
        pix_check("pre_rst", 306, 201, 12'h111, 1'b1, 0);
        #2 rst = 1'b1;
        #1;
        check_val("arst_pix",  32'(bus.pix_color),       32'h0);
        check_val("arst_any",  32'(bus.hit_any),         32'h0);
        check_val("arst_idx",  32'(bus.hit_idx),         32'h0);
        check_val("arst_coll", 32'(bus.collision),       32'h0);
        check_val("arst_cval", 32'(bus.collision_valid), 32'h0);
        step(2);
        rst = 1'b0;
        set_pix(900, 400);
        step(3);
        pulse_frame();
        check_val("coll_discard", 32'(bus.collision), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised pixel compositor for the VGA path: resolves LAYERS rectangular sprite layers plus a background into one 12-bit pixel per clock, with a fixed two-stage pipeline, per-layer enable, a transparency colour key, and game-state override colours. It also accumulates per-frame player-vs-layer collision flags. It sits between the sprite colour generators and VGA_driver's data input, replacing ad-hoc priority muxing in top.

## Interface
- LAYERS, 4: number of sprite layers, 2..8; layer 0 is the player and has the highest priority.
- X_W, 10: x coordinate and width field width.
- Y_W, 9: y coordinate and height field width.
- COLOR_W, 12: pixel colour width.
- TRANSP_KEY, 12'hF0F: layer colour treated as transparent.
- clk  in  1  pixel-domain clock.
- rst  in  1  asynchronous, active-high reset.
- game_state  in  2  00 initial, 01 running, 10 over, 11 success.
- x, y  in  X_W / Y_W  current scan position.
- frame_start  in  1  one-cycle pulse once per frame.
- layer_en  in  LAYERS  per-layer enable.
- layer_x, layer_w  in  LAYERS*X_W  top-left x and width, packed with layer i at [i*X_W +: X_W].
- layer_y, layer_h  in  LAYERS*Y_W  top-left y and height, packed.
- layer_color  in  LAYERS*COLOR_W  each layer's colour at (x,y), aligned with x/y.
- bg_color  in  COLOR_W  background colour at (x,y), aligned with x/y.
- pix_color  out  COLOR_W  composited pixel.
- hit_any  out  1  some opaque layer won the pixel.
- hit_idx  out  clog2(LAYERS)  index of the winning layer; 0 when hit_any=0.
- collision  out  LAYERS  bit i=1 means layer 0 and layer i overlapped opaquely in the last completed frame; bit 0 is always 0.
- collision_valid  out  1  one-cycle pulse when `collision` updates.

## Operation
- Stage 1 (registered):
  - rel_x = x − layer_x[i] (mod 2^X_W); rel_y likewise. No signed arithmetic.
  - in_box[i] = layer_en[i] & (rel_x < layer_w[i]) & (rel_y < layer_h[i]).
  - Left/top edge is inclusive; right/bottom edge is exclusive.
  - A zero width or zero height never hits.
  - opaque[i] = in_box[i] & (layer_color[i] ≠ TRANSP_KEY).
  - Colours, bg_color and game_state are registered alongside.
- Stage 2 (registered):
  - The lowest-index opaque layer wins.
  - If no layer is opaque: bg_color, except bg_color == TRANSP_KEY outputs 0.
- game_state override at stage 2, using the stage-1 copy of game_state:
  - 00 → 'hF00.
  - 01 → composited value.
  - 10 → bg_color with the key mapping applied, layers ignored.
  - 11 → 'h00F.
  - hit_any/hit_idx reflect the composite in all states.
- Collision:
  - acc[i] is set when stage-1 opaque[0] & opaque[i] and game_state == 01 (stage-1 copy).
  - On frame_start: collision ← acc, collision_valid=1 for one cycle, acc cleared.
  - A hit arriving in the same cycle as frame_start goes into the new accumulator only.

## Timing
- Latency: exactly 2 clocks from x/y/layer inputs to pix_color, hit_any and hit_idx. Throughput is 1 pixel per clock with no stalls.
- frame_start to collision/collision_valid: 1 clock.
- Reset (asynchronous): all pipeline registers, pix_color, hit_any, hit_idx, collision, collision_valid and acc go to 0.
- First valid output: the second clock edge after rst deasserts.
- rst asserted mid-frame: accumulated collisions are discarded, not reported.
- game_state changes take effect on the pixel whose x/y is sampled in the same cycle, i.e. with the same 2-clock latency.
- Layer coordinates near 2^X_W wrap modulo 2^X_W: layer_x=1020, w=10 covers x 1020..1023 and 0..5.

## Configuration
- COMPOSITOR_COLLISION_EN defined: the accumulator and collision logic are built as above.
- Undefined: no accumulator registers; collision and collision_valid are tied to 0; compositing is unchanged.

## Test plan
- Reset, then LAYERS=4, game_state=01, only layer 2 enabled at (100,50), 34×36, colour 'h0F0:
  - (100,50) and (133,85) → 'h0F0, hit_idx=2, two clocks later.
  - (134,50) and (100,86) → bg_color.
- Layers 0 and 1 overlap, both opaque:
  - Output is layer 0's colour, hit_idx=0.
  - Set layer 0 colour = 'hF0F → output is layer 1's colour, hit_idx=1.
- bg_color='hF0F with no layer hit → pix_color=0, hit_any=0.
- game_state=00 → 'hF00; 11 → 'h00F; 10 → bg_color, even where layer 0 is opaque.
- Layers 0 and 3 overlap opaquely for one pixel in the frame, then frame_start pulses:
  - One clock later collision=4'b1000 and collision_valid=1 for one cycle.
  - The next frame without overlap reports 0.
  - The same overlap with game_state=10 is never reported.
- rst asserted mid-output → all outputs are 0 immediately (asynchronous), before the next clk edge.
